// File: rtl/cdm_pkg.sv
// cdm_pkg: shared state encoding and datapath widths for the time-multiplexed multiplier scheduler.
package cdm_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;
    localparam int OP_W  = 8;
    localparam int NIB_W = 4;
    localparam int PP_W  = 12;
    localparam int RES_W = 16;
endpackage

// File: rtl/cdm_mul_sched_if.sv
// cdm_mul_sched_if: request/response bundle between the compute lanes (master) and the scheduler (slave).
interface cdm_mul_sched_if #(parameter int NUM_REQ = 2);
    import cdm_pkg::*;
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [OP_W*NUM_REQ-1:0] req_a;
    logic [OP_W*NUM_REQ-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [RES_W-1:0]        rsp_r;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;
    modport master(output req_valid, req_a, req_b, rsp_ready,
                   input req_ready, rsp_valid, rsp_r, rsp_id, busy);
    modport slave(input req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_r, rsp_id, busy);
endinterface

// File: rtl/cda.sv
// cda: 8x4 partial multiplier; carry-disregard (XOR-combined rows) unless CDM_SEQ_EXACT_EN selects an exact product.
module cda
    import cdm_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [NIB_W-1:0] b,
    output logic [PP_W-1:0]  r
);
`ifdef CDM_SEQ_EXACT_EN
    assign r = PP_W'(a) * PP_W'(b);
`else
    always_comb begin
        r = '0;
        for (int j = 0; j < NIB_W; j++) r = r ^ ((PP_W'(a) << j) & {PP_W{b[j]}});
    end
`endif
endmodule

// File: rtl/cdm_rr_arb.sv
// cdm_rr_arb: round-robin pick of the first valid requester after the last grant.
module cdm_rr_arb #(
    parameter int NUM_REQ = 2,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan farthest-first so the requester right after last wins on overwrite.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (valid[(int'(last) + k) % NUM_REQ]) begin
                idx = ID_W'((int'(last) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/cdm_mul_sched.sv
// cdm_mul_sched: round-robin scheduler sharing one 8x4 cda slice over two passes per 8x8 op.
// Build option CDM_SEQ_EXACT_EN (in cda) swaps the approximate slice for an exact one.
module cdm_mul_sched
    import cdm_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input logic             clk,
    input logic             rst_n,
    cdm_mul_sched_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    state_t             state, next;
    logic [OP_W-1:0]    a_q, b_q, cda_a;
    logic [NIB_W-1:0]   cda_b;
    logic [PP_W-1:0]    lo_q, cda_r;
    logic [ID_W-1:0]    id_q, last_q, g_idx;
    logic [NUM_REQ-1:0] g_oh;
    logic               g_any;

    cdm_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid(bus.req_valid), .last(last_q), .grant(g_oh), .idx(g_idx), .any(g_any)
    );

    cda u_cda (.a(cda_a), .b(cda_b), .r(cda_r));

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = g_any ? LO : IDLE;
            LO:      next = HI;
            HI:      next = RSP;
            RSP:     next = bus.rsp_ready ? IDLE : RSP;
            default: next = IDLE;
        endcase
    end

    // Slice inputs parked at zero outside the two compute passes to cut toggling.
    assign cda_a         = (state == LO || state == HI) ? a_q : '0;
    assign cda_b         = (state == LO) ? b_q[NIB_W-1:0] : (state == HI) ? b_q[OP_W-1:NIB_W] : '0;
    assign bus.req_ready = (state == IDLE && rst_n) ? g_oh : '0;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            lo_q          <= '0;
            bus.rsp_r     <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            if (state == IDLE && g_any) begin
                a_q    <= bus.req_a[g_idx*OP_W +: OP_W];
                b_q    <= bus.req_b[g_idx*OP_W +: OP_W];
                id_q   <= g_idx;
                last_q <= g_idx;
            end
            if (state == LO) lo_q <= cda_r;
            if (state == HI) begin
                bus.rsp_r     <= {cda_r, {NIB_W{1'b0}}} + {{NIB_W{1'b0}}, lo_q};
                bus.rsp_id    <= id_q;
                bus.rsp_valid <= 1'b1;
            end
            if (state == RSP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end
endmodule
